// File: rtl/conv_tm_pkg.sv
// conv_tm_pkg: shared definitions for the convolutional Tsetlin clause engine.
//   - default geometry and derived literal widths (PL/YL/XL/L/CW/SW)
//   - FSM state encoding
//   - clause polarity helper (even clause votes +1, odd clause votes -1)
package conv_tm_pkg;

  localparam int IMG_WIDTH_D  = 32;
  localparam int IMG_HEIGHT_D = 32;
  localparam int PATCH_D      = 3;
  localparam int NPE_D        = 8;
  localparam int CLAUSEN_D    = 10;
  localparam int CLASSN_D     = 5;

  localparam int PL_D = PATCH_D * PATCH_D;
  localparam int YL_D = IMG_HEIGHT_D - PATCH_D;
  localparam int XL_D = IMG_WIDTH_D - PATCH_D;
  localparam int L_D  = PL_D + YL_D + XL_D;
  localparam int CW_D = 2 * L_D;
  localparam int SW_D = $clog2(CLAUSEN_D) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_EVAL,
    S_FLUSH,
    S_EMIT,
    S_DONE
  } state_e;

  function automatic int polarity(input int idx);
    return idx[0] ? -1 : 1;
  endfunction

  // $clog2 that never yields a zero-width field
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_clause_engine_if.sv
// conv_clause_engine_if: patch-beat stream from the patch generator.
//   master: patch generator (drives beats, sees in_ready)
//   slave : clause engine (consumes beats, drives in_ready)
//   in_pix/in_ypos/in_xpos are packed per channel, channel k at [k*W +: W].
interface conv_clause_engine_if #(
  parameter int NPE = conv_tm_pkg::NPE_D,
  parameter int PL  = conv_tm_pkg::PL_D,
  parameter int YL  = conv_tm_pkg::YL_D,
  parameter int XL  = conv_tm_pkg::XL_D
);
  logic              in_valid;
  logic              in_ready;
  logic [NPE-1:0]    in_pe_en;
  logic [NPE*PL-1:0] in_pix;
  logic [NPE*YL-1:0] in_ypos;
  logic [NPE*XL-1:0] in_xpos;
  logic              in_last;

  modport master (
    output in_valid, in_pe_en, in_pix, in_ypos, in_xpos, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_pe_en, in_pix, in_ypos, in_xpos, in_last,
    output in_ready
  );
endinterface

// File: rtl/clause_match_pe.sv
// clause_match_pe: combinational match of one patch channel against a clause.
//   en_i      channel valid
//   pix_i     patch pixels, ypos_i/xpos_i thermometer position literals
//   pos_inc_i literals that must be 1, neg_inc_i literals that must be 0
//   match_o   channel satisfies every included literal
module clause_match_pe #(
  parameter  int PL = 9,
  parameter  int YL = 29,
  parameter  int XL = 29,
  localparam int L  = PL + YL + XL
) (
  input  logic          en_i,
  input  logic [PL-1:0] pix_i,
  input  logic [YL-1:0] ypos_i,
  input  logic [XL-1:0] xpos_i,
  input  logic [L-1:0]  pos_inc_i,
  input  logic [L-1:0]  neg_inc_i,
  output logic          match_o
);
  logic [L-1:0] lit;

  assign lit     = {xpos_i, ypos_i, pix_i};
  assign match_o = en_i & (&(lit | ~pos_inc_i)) & (&(~lit | ~neg_inc_i));
endmodule

// File: rtl/conv_clause_engine.sv
// conv_clause_engine: clause memory plus per-class clause evaluation.
//   clk/rst         clock, async active-high reset
//   start_i         begin class class_id_i (IDLE only); abort_i returns to IDLE
//   wr_en_i/addr/data  clause memory write port (IDLE only), wr_err_o flags drops
//   s_if            patch-beat stream (slave side)
//   busy_o          engine not idle
//   clause_valid_o/clause_out_o/clause_idx_o  one report per clause
//   sum_valid_o/class_sum_o   polarity-weighted class sum after last clause
module conv_clause_engine
  import conv_tm_pkg::*;
#(
  parameter  int IMG_WIDTH  = IMG_WIDTH_D,
  parameter  int IMG_HEIGHT = IMG_HEIGHT_D,
  parameter  int PATCH      = PATCH_D,
  parameter  int NPE        = NPE_D,
  parameter  int CLAUSEN    = CLAUSEN_D,
  parameter  int CLASSN     = CLASSN_D,
  localparam int PL    = PATCH * PATCH,
  localparam int YL    = IMG_HEIGHT - PATCH,
  localparam int XL    = IMG_WIDTH - PATCH,
  localparam int L     = PL + YL + XL,
  localparam int CW    = 2 * L,
  localparam int SW    = $clog2(CLAUSEN) + 1,
  localparam int DEPTH = CLASSN * CLAUSEN,
  localparam int CIW   = clog2_min1(CLASSN),
  localparam int IW    = clog2_min1(CLAUSEN),
  localparam int AW    = clog2_min1(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [CIW-1:0]       class_id_i,
  input  logic                 abort_i,
  input  logic                 wr_en_i,
  input  logic [AW-1:0]        wr_addr_i,
  input  logic [CW-1:0]        wr_data_i,
  output logic                 wr_err_o,
  conv_clause_engine_if.slave  s_if,
  output logic                 busy_o,
  output logic                 clause_valid_o,
  output logic                 clause_out_o,
  output logic [IW-1:0]        clause_idx_o,
  output logic                 sum_valid_o,
  output logic signed [SW-1:0] class_sum_o
);

  state_e               state_q, state_d;
  logic [CIW-1:0]       class_q;
  logic [IW-1:0]        idx_q;
  logic [CW-1:0]        clause_q, rdata_q;
  logic [NPE-1:0]       m, m_q;
  logic                 acc_q;
  logic signed [SW-1:0] sum_q, sum_d, sum_out_q, delta;
  logic                 wr_err_q;
  logic [AW-1:0]        raddr;
  logic                 hs, last_idx, clause_res, wr_ok;

  logic [CW-1:0] mem [DEPTH];

  assign hs         = (state_q == S_EVAL) && s_if.in_valid;
  assign last_idx   = (idx_q == IW'(CLAUSEN - 1));
  // an all-zero clause would trivially match; it must report 0
  assign clause_res = acc_q & (|clause_q);
  assign delta      = clause_res ? SW'(polarity(int'(idx_q))) : '0;
  assign sum_d      = sum_q + delta;
  assign raddr      = AW'(int'(class_q) * CLAUSEN + int'(idx_q));
  assign wr_ok      = wr_en_i && (state_q == S_IDLE) &&
                      ({1'b0, wr_addr_i} < (AW + 1)'(DEPTH));

  // clause memory: not reset, registered read
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr_i] <= wr_data_i;
    rdata_q <= mem[raddr];
  end

  for (genvar k = 0; k < NPE; k++) begin : g_pe
    clause_match_pe #(.PL(PL), .YL(YL), .XL(XL)) u_pe (
      .en_i      (s_if.in_pe_en[k]),
      .pix_i     (s_if.in_pix[k*PL +: PL]),
      .ypos_i    (s_if.in_ypos[k*YL +: YL]),
      .xpos_i    (s_if.in_xpos[k*XL +: XL]),
      .pos_inc_i (clause_q[L-1:0]),
      .neg_inc_i (clause_q[CW-1:L]),
      .match_o   (m[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    busy_o         = (state_q != S_IDLE);
    s_if.in_ready  = (state_q == S_EVAL);
    // an abort in the reporting cycle suppresses the report
    clause_valid_o = (state_q == S_EMIT) && !abort_i;
    clause_out_o   = clause_valid_o && clause_res;
    clause_idx_o   = idx_q;
    sum_valid_o    = (state_q == S_DONE) && !abort_i;
    class_sum_o    = sum_out_q;
    wr_err_o       = wr_err_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_LOAD;
      S_LOAD:  state_d = S_WAIT;
      S_WAIT:  state_d = S_EVAL;
      S_EVAL:  if (hs && s_if.in_last) state_d = S_FLUSH;
      S_FLUSH: state_d = S_EMIT;
      S_EMIT:  state_d = last_idx ? S_DONE : S_LOAD;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      class_q   <= '0;
      idx_q     <= '0;
      clause_q  <= '0;
      m_q       <= '0;
      acc_q     <= 1'b0;
      sum_q     <= '0;
      sum_out_q <= '0;
      wr_err_q  <= 1'b0;
    end else begin
      wr_err_q <= wr_en_i && (state_q != S_IDLE);
      if (abort_i) begin
        m_q   <= '0;
        acc_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (start_i) begin
            class_q <= class_id_i;
            idx_q   <= '0;
            sum_q   <= '0;
            acc_q   <= 1'b0;
            m_q     <= '0;
          end
          S_WAIT: clause_q <= rdata_q;
          // match vector is one stage behind the handshake; fold it a cycle later
          S_EVAL: begin
            m_q   <= hs ? m : '0;
            acc_q <= acc_q | (|m_q);
          end
          S_FLUSH: begin
            acc_q <= acc_q | (|m_q);
            m_q   <= '0;
          end
          S_EMIT: begin
            sum_q <= sum_d;
            if (last_idx) begin
              sum_out_q <= sum_d;
            end else begin
              idx_q <= idx_q + IW'(1);
              acc_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_clause_engine.sv
// tb_conv_clause_engine: directed vectors with hand-computed expectations.
module tb_conv_clause_engine;
  localparam int NPE = 8, PL = 9, YL = 29, XL = 29;
  localparam int L = PL + YL + XL, CW = 2 * L;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start_i = 1'b0, abort_i = 1'b0, wr_en_i = 1'b0;
  logic [2:0]          class_id_i = '0;
  logic [5:0]          wr_addr_i = '0;
  logic [CW-1:0]       wr_data_i = '0;
  logic                wr_err_o, busy_o, clause_valid_o, clause_out_o, sum_valid_o;
  logic [3:0]          clause_idx_o;
  logic signed [4:0]   class_sum_o;

  conv_clause_engine_if #(.NPE(NPE), .PL(PL), .YL(YL), .XL(XL)) bus ();

  conv_clause_engine dut (
    .clk(clk), .rst(rst), .start_i(start_i), .class_id_i(class_id_i),
    .abort_i(abort_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .wr_err_o(wr_err_o), .s_if(bus.slave),
    .busy_o(busy_o), .clause_valid_o(clause_valid_o), .clause_out_o(clause_out_o),
    .clause_idx_o(clause_idx_o), .sum_valid_o(sum_valid_o), .class_sum_o(class_sum_o)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // beat table replayed for every clause of a pass
  int                nb;
  logic [NPE-1:0]    b_en  [4];
  logic [NPE*PL-1:0] b_pix [4];
  logic [NPE*YL-1:0] b_y   [4];
  logic [NPE*XL-1:0] b_x   [4];

  function automatic logic [CW-1:0] pos(input int b);
    logic [CW-1:0] w;
    w = '0; w[b] = 1'b1;
    return w;
  endfunction

  function automatic logic [CW-1:0] neg(input int b);
    logic [CW-1:0] w;
    w = '0; w[L+b] = 1'b1;
    return w;
  endfunction

  task automatic wr_word(input int addr, input logic [CW-1:0] d);
    wr_en_i = 1'b1; wr_addr_i = 6'(addr); wr_data_i = d;
    tick;
    wr_en_i = 1'b0;
  endtask

  task automatic wr_class(input int cls, input logic [CW-1:0] w0, input logic [CW-1:0] we,
                          input logic [CW-1:0] wo);
    for (int k = 0; k < 10; k++)
      wr_word(cls * 10 + k, (k == 0) ? w0 : ((k % 2 == 0) ? we : wo));
  endtask

  task automatic wait_ready;
    int n;
    n = 0;
    while (!bus.in_ready && n < 10) begin tick; n++; end
    chk("in_ready", bus.in_ready, 1);
  endtask

  task automatic run_class(input int cls, input logic [9:0] exp_bits, input int exp_sum,
                           input int abort_at, input bit poke);
    int seen;
    start_i = 1'b1; class_id_i = 3'(cls);
    tick;
    start_i = 1'b0;
    chk("busy_start", busy_o, 1);
    if (poke) begin
      wr_en_i = 1'b1; wr_addr_i = 6'(cls * 10); wr_data_i = '0;
      tick;
      wr_en_i = 1'b0;
      chk("wr_err_pulse", wr_err_o, 1);
      tick;
      chk("wr_err_clear", wr_err_o, 0);
    end else begin
      chk("rdy_load", bus.in_ready, 0);
      tick;
      chk("rdy_wait", bus.in_ready, 0);
      tick;
      chk("rdy_eval", bus.in_ready, 1);
    end
    for (int k = 0; k < 10; k++) begin
      wait_ready;
      if (k == abort_at) begin
        abort_i = 1'b1;
        tick;
        abort_i = 1'b0;
        chk("abort_busy", busy_o, 0);
        seen = 0;
        repeat (8) begin
          if (clause_valid_o || sum_valid_o) seen++;
          tick;
        end
        chk("abort_quiet", seen, 0);
        chk("abort_sum", class_sum_o, exp_sum);
        return;
      end
      for (int b = 0; b < nb; b++) begin
        bus.in_valid = 1'b1; bus.in_pe_en = b_en[b]; bus.in_pix = b_pix[b];
        bus.in_ypos = b_y[b]; bus.in_xpos = b_x[b]; bus.in_last = (b == nb - 1);
        tick;
      end
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
      chk("flush_novalid", clause_valid_o, 0);
      tick;
      chk("clause_valid", clause_valid_o, 1);
      chk("clause_out", clause_out_o, exp_bits[k]);
      chk("clause_idx", clause_idx_o, k);
      tick;
      if (k == 9) begin
        chk("sum_valid", sum_valid_o, 1);
        chk("class_sum", class_sum_o, exp_sum);
        tick;
        chk("idle_after", busy_o, 0);
        chk("sum_hold", class_sum_o, exp_sum);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NPE*PL-1:0] pix_all4, pix_ch0, pix_ch7;
    logic [NPE*YL-1:0] y5;
    logic [NPE*XL-1:0] x5;
    pix_all4 = {NPE{9'h010}};
    pix_ch0  = '0; pix_ch0[4] = 1'b1;
    pix_ch7  = '0; pix_ch7[7*PL+4] = 1'b1;
    y5 = '0; y5[5*YL+3] = 1'b1;
    x5 = '0; x5[5*XL+2] = 1'b1;

    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_pe_en = '0;
    bus.in_pix = '0; bus.in_ypos = '0; bus.in_xpos = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", bus.in_ready, 0);
    chk("rst_wr_err", wr_err_o, 0);
    chk("rst_cvalid", clause_valid_o, 0);
    chk("rst_cout", clause_out_o, 0);
    chk("rst_cidx", clause_idx_o, 0);
    chk("rst_svalid", sum_valid_o, 0);
    chk("rst_sum", class_sum_o, 0);
    rst = 1'b0;
    tick;

    wr_class(2, pos(4), '0, '0);
    wr_class(1, neg(4), pos(4), pos(4));
    wr_class(3, pos(4), pos(4), pos(4));
    wr_class(4, pos(4), pos(4), pos(5));
    wr_class(0, pos(PL+3), pos(PL+3), pos(PL+3) | pos(PL+YL+2));

    // single pixel include, empty clauses 1..9
    nb = 1; b_en[0] = 8'h01; b_pix[0] = pix_ch0; b_y[0] = '0; b_x[0] = '0;
    run_class(2, 10'h001, 1, -1, 0);

    // negated include on clause 0, others positive
    nb = 1; b_en[0] = 8'hFF; b_pix[0] = pix_all4;
    run_class(1, 10'h3FE, -1, -1, 0);

    // multi-beat: disabled beat, non-matching beat, match on last beat only
    nb = 3;
    b_en[0] = 8'h00; b_pix[0] = pix_all4; b_y[0] = '0; b_x[0] = '0;
    b_en[1] = 8'hFF; b_pix[1] = '0;       b_y[1] = '0; b_x[1] = '0;
    b_en[2] = 8'h80; b_pix[2] = pix_ch7;  b_y[2] = '0; b_x[2] = '0;
    run_class(3, 10'h3FF, 0, -1, 0);

    // only even clauses match
    nb = 1; b_en[0] = 8'hFF; b_pix[0] = pix_all4; b_y[0] = '0; b_x[0] = '0;
    run_class(4, 10'h155, 5, -1, 0);

    // position literals, channel 5 gated off then on
    nb = 1; b_en[0] = 8'hDF; b_pix[0] = '0; b_y[0] = y5; b_x[0] = x5;
    run_class(0, 10'h000, 0, -1, 0);
    b_en[0] = 8'hFF;
    run_class(0, 10'h3FF, 0, -1, 0);
    b_x[0] = '0;
    run_class(0, 10'h155, 5, -1, 0);

    // start with abort in IDLE: abort wins
    start_i = 1'b1; abort_i = 1'b1;
    tick;
    start_i = 1'b0; abort_i = 1'b0;
    chk("start_abort_idle", busy_o, 0);

    // dropped write while busy, then abort during clause 4
    nb = 1; b_en[0] = 8'h01; b_pix[0] = pix_ch0; b_y[0] = '0; b_x[0] = '0;
    run_class(2, 10'h001, 5, 4, 1);
    run_class(2, 10'h001, 1, -1, 0);

    // async reset in EVAL
    start_i = 1'b1; class_id_i = 3'd3;
    tick;
    start_i = 1'b0;
    wait_ready;
    bus.in_valid = 1'b1; bus.in_pe_en = 8'hFF; bus.in_pix = pix_all4; bus.in_last = 1'b0;
    tick;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_ready", bus.in_ready, 0);
    chk("mid_rst_cvalid", clause_valid_o, 0);
    chk("mid_rst_sum", class_sum_o, 0);
    chk("mid_rst_cidx", clause_idx_o, 0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    tick;
    // clause memory survives reset
    nb = 1; b_en[0] = 8'hFF; b_pix[0] = pix_all4; b_y[0] = '0; b_x[0] = '0;
    run_class(4, 10'h155, 5, -1, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
